alu_16_bits: RTL and testbench
==============================

# alu_16_bits

16-bit add/subtract ALU with N/Z/V/C condition flags, used as the datapath arithmetic unit of the multiple-cycle 16-bit RISC computer. The S and NZVC outputs are purely combinational from A, B, ALU_CTRL and Cin_Ctrl. A small clocked flag register, NZVC_Q, captures NZVC on command so the control unit can use the flags in later cycles.

## Interface
Parameters: none (width fixed at 16).
- CLK  input  1  system clock, rising-edge active
- RST_N  input  1  asynchronous, active-low reset; clears NZVC_Q only
- A  input  16  operand A
- B  input  16  operand B
- ALU_CTRL  input  1  0 = add, 1 = subtract (B inverted)
- Cin_Ctrl  input  1  carry/borrow-chain control bit (see Operation)
- FLAG_WE  input  1  when 1, NZVC_Q loads NZVC at the next CLK rise
- S  output  16  result, combinational
- NZVC  output  4  flags, combinational: [3]=N, [2]=Z, [1]=V, [0]=C
- NZVC_Q  output  4  registered copy of NZVC, same bit order

One clock; reset is asynchronous and active-low. The ports are named CLK and RST_N.

## Operation
Internal operand and carry-in:
- Bx = B XOR {16{ALU_CTRL}}.
- cin = ALU_CTRL XOR Cin_Ctrl.

Sum:
- {cout, S} = A + Bx + cin, computed as a 17-bit unsigned sum.
- ALU_CTRL=0, Cin_Ctrl=0: S = A + B.
- ALU_CTRL=0, Cin_Ctrl=1: S = A + B + 1 (add with carry).
- ALU_CTRL=1, Cin_Ctrl=0: S = A − B (two's complement, A + ~B + 1).
- ALU_CTRL=1, Cin_Ctrl=1: S = A − B − 1 (A + ~B + 0, subtract with borrow).

Flags:
- N = S[15].
- Z = 1 iff S == 16'h0000.
- V = (A[15] == Bx[15]) && (S[15] != A[15]). This is signed overflow of the actual addition performed.
- C = cout, the raw adder carry-out. It is never inverted in subtract mode, so C=1 means "no borrow".

Rules:
- All arithmetic is modulo 2^16, with wrap-around and no saturation.
- Operands are unsigned bit vectors. V is the only signed interpretation.
- Structure is free (ripple or lookahead) as long as the results are bit-exact.

## Timing
- S and NZVC have zero-cycle latency. They are purely combinational, have no dependence on CLK or RST_N, and are valid whenever the inputs are stable.
- NZVC_Q: on a CLK rising edge with FLAG_WE=1, NZVC_Q <= NZVC. With FLAG_WE=0 it holds its value.
- RST_N low forces NZVC_Q = 4'b0000 immediately, independent of CLK. This overrides FLAG_WE and applies even mid-operation.
- After RST_N deasserts, the first capture occurs on the first CLK rise with FLAG_WE=1.
- Reset value of every output: NZVC_Q = 0000. S and NZVC always track the inputs, including during reset.

## Test plan
- Add: A=0001, B=0002, ALU_CTRL=0, Cin_Ctrl=0 -> S=0003, NZVC=0000.
- Signed overflow: A=7FFF, B=0001, ctrl 0/0 -> S=8000, NZVC=1010. Wrap to zero: A=FFFF, B=0001, ctrl 0/0 -> S=0000, NZVC=0101.
- Add with carry: A=FFFF, B=0005, ALU_CTRL=0, Cin_Ctrl=1 -> S=0005, NZVC=0001.
- Subtract: A=0000, B=0005, ALU_CTRL=1, Cin_Ctrl=0 -> S=FFFB, NZVC=1000. Subtract with borrow: A=FFFF, B=0005, ALU_CTRL=1, Cin_Ctrl=1 -> S=FFF9, NZVC=1001.
- Flag register:
  - Hold RST_N=0 -> NZVC_Q=0000.
  - Release RST_N, apply the 7FFF+1 vector with FLAG_WE=1 and one CLK rise -> NZVC_Q=1010.
  - Set FLAG_WE=0, change inputs, clock -> NZVC_Q stays 1010.
  - Drop RST_N between clock edges -> NZVC_Q=0000 immediately.
- Random sweep: 10k random A, B, ALU_CTRL and Cin_Ctrl, checked against the 17-bit reference model A + (B ^ {16{ALU_CTRL}}) + (ALU_CTRL ^ Cin_Ctrl) for S and all four flags.

Source files
------------

// File: rtl/alu_16_bits.sv
// rtl/alu_16_bits.sv - 16-bit add/subtract ALU with combinational NZVC flags and a captured flag register
module alu_16_bits (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        ALU_CTRL,
  input  logic        Cin_Ctrl,
  input  logic        FLAG_WE,
  output logic [15:0] S,
  output logic [3:0]  NZVC,
  output logic [3:0]  NZVC_Q
);

  logic [15:0] w_bx;
  logic        w_cin;
  logic [16:0] w_sum;
  logic        w_n;
  logic        w_z;
  logic        w_v;
  logic        w_c;
  logic [3:0]  r_nzvc_q;

  // Subtract is A + ~B + 1; Cin_Ctrl flips the carry-in to give add-with-carry / subtract-with-borrow.
  assign w_bx  = B ^ {16{ALU_CTRL}};
  assign w_cin = ALU_CTRL ^ Cin_Ctrl;
  assign w_sum = {1'b0, A} + {1'b0, w_bx} + {16'h0000, w_cin};

  assign S = w_sum[15:0];

  assign w_n = w_sum[15];
  assign w_z = (w_sum[15:0] == 16'h0000);
  assign w_v = (A[15] == w_bx[15]) && (w_sum[15] != A[15]);
  // Raw carry-out: in subtract mode C=1 means no borrow.
  assign w_c = w_sum[16];

  assign NZVC = {w_n, w_z, w_v, w_c};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_nzvc_q <= 4'b0000;
    end else if (FLAG_WE) begin
      r_nzvc_q <= NZVC;
    end
  end

  assign NZVC_Q = r_nzvc_q;

endmodule

// File: tb/tb_alu_16_bits.sv
// tb/tb_alu_16_bits.sv - scoreboard bench for alu_16_bits against an integer reference model
module tb_alu_16_bits;

  logic        CLK;
  logic        RST_N;
  logic [15:0] A;
  logic [15:0] B;
  logic        ALU_CTRL;
  logic        Cin_Ctrl;
  logic        FLAG_WE;
  logic [15:0] S;
  logic [3:0]  NZVC;
  logic [3:0]  NZVC_Q;

  alu_16_bits dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .A        (A),
    .B        (B),
    .ALU_CTRL (ALU_CTRL),
    .Cin_Ctrl (Cin_Ctrl),
    .FLAG_WE  (FLAG_WE),
    .S        (S),
    .NZVC     (NZVC),
    .NZVC_Q   (NZVC_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] s;
    logic [3:0]  nzvc;
    logic [3:0]  nzvc_q;
    string       name;
  } txn_t;

  txn_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [3:0]  model_q = 4'b0000;

  // Reference: unsigned and signed integer sums evaluated independently.
  function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic ctl, input logic cin);
    int ua, ub, c, usum, sa, sb, ssum, s;
    logic n, z, v, cy;
    ua   = int'(a);
    ub   = ctl ? (65535 - int'(b)) : int'(b);
    c    = (ctl != cin) ? 1 : 0;
    usum = ua + ub + c;
    s    = usum % 65536;
    cy   = (usum >= 65536);
    sa   = (ua >= 32768) ? ua - 65536 : ua;
    sb   = (ub >= 32768) ? ub - 65536 : ub;
    ssum = sa + sb + c;
    v    = (ssum > 32767) || (ssum < -32768);
    n    = (s >= 32768);
    z    = (s == 0);
    return {s[15:0], n, z, v, cy};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one vector just after a rising edge and push its expectation.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ctl,
                       input logic cin, input logic fwe, input logic rstn,
                       input bit use_exp, input logic [15:0] es, input logic [3:0] en,
                       input string nm);
    txn_t t;
    logic [19:0] r;
    @(posedge CLK);
    if (RST_N && FLAG_WE) model_q = ref_model(A, B, ALU_CTRL, Cin_Ctrl)[3:0];
    #1;
    A = a; B = b; ALU_CTRL = ctl; Cin_Ctrl = cin; FLAG_WE = fwe; RST_N = rstn;
    if (!rstn) model_q = 4'b0000;
    r = ref_model(a, b, ctl, cin);
    t.s      = use_exp ? es : r[19:4];
    t.nzvc   = use_exp ? en : r[3:0];
    t.nzvc_q = model_q;
    t.name   = nm;
    sb_q.push_back(t);
  endtask

  initial begin : monitor
    txn_t t;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        t = sb_q.pop_front();
        chk({t.name, ".S"},      S,               t.s);
        chk({t.name, ".NZVC"},   {12'h000, NZVC},   {12'h000, t.nzvc});
        chk({t.name, ".NZVC_Q"}, {12'h000, NZVC_Q}, {12'h000, t.nzvc_q});
      end
    end
  end

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin : stimulus
    int wait_cyc;
    RST_N = 1'b0; A = '0; B = '0; ALU_CTRL = 1'b0; Cin_Ctrl = 1'b0; FLAG_WE = 1'b1;

    issue(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 1, 16'h0003, 4'b0000, "add_in_reset");
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1, 16'h8000, 4'b1010, "ovf_release");
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1, 16'h0000, 4'b0101, "wrap_zero_hold");
    issue(16'hFFFF, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b1, 1, 16'h0005, 4'b0001, "adc_hold");
    issue(16'h0000, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 1, 16'hFFFB, 4'b1000, "sub_async_rst");
    issue(16'hFFFF, 16'h0005, 1'b1, 1'b1, 1'b1, 1'b1, 1, 16'hFFF9, 4'b1001, "sbb_capture");

    for (int i = 0; i < 10000; i++) begin
      issue(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), 1'($urandom),
            1'b1, 0, 16'h0000, 4'b0000, "rand");
    end

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge CLK);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
